// File: rtl/lpc_io_slave.sv
// LPC I/O-cycle target: decodes host I/O read/write cycles aimed at a 4-byte
// window and turns them into single-cycle register-block strobes.
module lpc_io_slave #(
    parameter logic [15:0] BASE_ADDR = 16'h0A00,
    parameter int unsigned SYNC_WAIT = 0
) (
    input  logic       i_lpc_clk,
    input  logic       i_lpc_rst,
    input  logic       i_lframe_n,
    input  logic [3:0] i_lad,
    output logic [3:0] o_lad,
    output logic       o_lad_oe,
    output logic       o_lpc_ce,
    output logic       o_lpc_we,
    output logic       o_lpc_oe,
    output logic [1:0] o_lpc_addr,
    output logic [7:0] o_lpc_data,
    input  logic [7:0] i_lpc_data,
    output logic       o_busy
);

    localparam logic [3:0] LAD_READY = 4'b0000;
    localparam logic [3:0] LAD_WAIT  = 4'b0101;
    localparam logic [3:0] LAD_IDLE  = 4'b1111;
    localparam logic [3:0] WAIT_LAST = 4'(SYNC_WAIT);

    typedef enum logic [2:0] {
        IDLE,
        CYC,
        ADDR,
        WDATA,
        HTAR,
        SYNC,
        RDATA,
        PTAR
    } state_t;

    state_t      state;
    logic [1:0]  nib_cnt;
    logic [3:0]  wait_cnt;
    logic        is_write;
    logic [11:0] addr_sr;
    logic [3:0]  rdata_hi;
    logic [15:0] full_addr;
    logic        addr_hit;

    // Address as it will stand once the current nibble is shifted in.
    assign full_addr = {addr_sr, i_lad};
    assign addr_hit  = (full_addr[15:2] == BASE_ADDR[15:2]);

    always_ff @(posedge i_lpc_clk) begin
        if (i_lpc_rst) begin
            state      <= IDLE;
            nib_cnt    <= '0;
            wait_cnt   <= '0;
            is_write   <= 1'b0;
            addr_sr    <= '0;
            rdata_hi   <= '0;
            o_lad      <= LAD_IDLE;
            o_lad_oe   <= 1'b0;
            o_lpc_ce   <= 1'b0;
            o_lpc_we   <= 1'b0;
            o_lpc_oe   <= 1'b0;
            o_lpc_addr <= '0;
            o_lpc_data <= '0;
            o_busy     <= 1'b0;
        end else if (!i_lframe_n) begin
            // LFRAME# low always wins: abort whatever is in flight.
            state    <= (i_lad == 4'b0000) ? CYC : IDLE;
            nib_cnt  <= '0;
            o_lad    <= LAD_IDLE;
            o_lad_oe <= 1'b0;
            o_lpc_ce <= 1'b0;
            o_lpc_we <= 1'b0;
            o_lpc_oe <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    nib_cnt <= '0;
                end

                CYC: begin
                    nib_cnt <= '0;
                    if (i_lad[3:1] == 3'b000) begin
                        is_write <= 1'b0;
                        state    <= ADDR;
                    end else if (i_lad[3:1] == 3'b001) begin
                        is_write <= 1'b1;
                        state    <= ADDR;
                    end else begin
                        state <= IDLE;
                    end
                end

                ADDR: begin
                    addr_sr <= full_addr[11:0];
                    nib_cnt <= nib_cnt + 2'd1;
                    if (nib_cnt == 2'd3) begin
                        nib_cnt <= '0;
                        if (!addr_hit) begin
                            state <= IDLE;
                        end else begin
                            o_lpc_addr <= full_addr[1:0];
                            o_busy     <= 1'b1;
                            if (is_write) begin
                                state <= WDATA;
                            end else begin
                                state    <= HTAR;
                                o_lpc_ce <= 1'b1;
                                o_lpc_oe <= 1'b1;
                            end
                        end
                    end
                end

                WDATA: begin
                    if (nib_cnt == 2'd0) begin
                        o_lpc_data[3:0] <= i_lad;
                        nib_cnt         <= 2'd1;
                    end else begin
                        o_lpc_data[7:4] <= i_lad;
                        nib_cnt         <= '0;
                        state           <= HTAR;
                    end
                end

                HTAR: begin
                    if (nib_cnt == 2'd0) begin
                        nib_cnt <= 2'd1;
                    end else begin
                        nib_cnt  <= '0;
                        wait_cnt <= '0;
                        state    <= SYNC;
                        o_lad_oe <= 1'b1;
                        if (WAIT_LAST == 4'd0) begin
                            o_lad <= LAD_READY;
                            if (is_write) begin
                                o_lpc_ce <= 1'b1;
                                o_lpc_we <= 1'b1;
                            end
                        end else begin
                            o_lad <= LAD_WAIT;
                        end
                    end
                end

                SYNC: begin
                    if (wait_cnt == WAIT_LAST) begin
                        // Ready SYNC clock ends here: strobes drop, read byte is taken.
                        o_lpc_ce <= 1'b0;
                        o_lpc_we <= 1'b0;
                        o_lpc_oe <= 1'b0;
                        nib_cnt  <= '0;
                        if (is_write) begin
                            state <= PTAR;
                            o_lad <= LAD_IDLE;
                        end else begin
                            state    <= RDATA;
                            o_lad    <= i_lpc_data[3:0];
                            rdata_hi <= i_lpc_data[7:4];
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                        if (wait_cnt + 4'd1 == WAIT_LAST) begin
                            o_lad <= LAD_READY;
                            if (is_write) begin
                                o_lpc_ce <= 1'b1;
                                o_lpc_we <= 1'b1;
                            end
                        end
                    end
                end

                RDATA: begin
                    if (nib_cnt == 2'd0) begin
                        o_lad   <= rdata_hi;
                        nib_cnt <= 2'd1;
                    end else begin
                        o_lad   <= LAD_IDLE;
                        nib_cnt <= '0;
                        state   <= PTAR;
                    end
                end

                PTAR: begin
                    if (nib_cnt == 2'd0) begin
                        o_lad_oe <= 1'b0;
                        nib_cnt  <= 2'd1;
                    end else begin
                        nib_cnt <= '0;
                        o_busy  <= 1'b0;
                        state   <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lpc_io_slave.sv
// Bench for lpc_io_slave: two instances (SYNC_WAIT 0 and 3), a table of
// directed transactions, hand-written abort/reset sequences and random cycles.
module tb_lpc_io_slave;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst      [2];
    logic       lframe_n [2];
    logic [3:0] lad_i    [2];
    logic [3:0] lad_o    [2];
    logic       lad_oe   [2];
    logic       ce       [2];
    logic       we       [2];
    logic       oe       [2];
    logic [1:0] addr_o   [2];
    logic [7:0] data_o   [2];
    logic [7:0] rd       [2];
    logic       busy     [2];
    logic [7:0] regmem   [2][4];
    int         we_cnt   [2] = '{0, 0};

    int n_tests = 0;
    int n_fail  = 0;
    int cur_inst;
    int cur_cyc;

    lpc_io_slave #(.BASE_ADDR(16'h0A00), .SYNC_WAIT(0)) dut0 (
        .i_lpc_clk(clk), .i_lpc_rst(rst[0]), .i_lframe_n(lframe_n[0]),
        .i_lad(lad_i[0]), .o_lad(lad_o[0]), .o_lad_oe(lad_oe[0]),
        .o_lpc_ce(ce[0]), .o_lpc_we(we[0]), .o_lpc_oe(oe[0]),
        .o_lpc_addr(addr_o[0]), .o_lpc_data(data_o[0]),
        .i_lpc_data(rd[0]), .o_busy(busy[0])
    );

    lpc_io_slave #(.BASE_ADDR(16'h0A00), .SYNC_WAIT(3)) dut1 (
        .i_lpc_clk(clk), .i_lpc_rst(rst[1]), .i_lframe_n(lframe_n[1]),
        .i_lad(lad_i[1]), .o_lad(lad_o[1]), .o_lad_oe(lad_oe[1]),
        .o_lpc_ce(ce[1]), .o_lpc_we(we[1]), .o_lpc_oe(oe[1]),
        .o_lpc_addr(addr_o[1]), .o_lpc_data(data_o[1]),
        .i_lpc_data(rd[1]), .o_busy(busy[1])
    );

    // Register block stand-in: read data registered one clock behind the address.
    always @(posedge clk) begin
        rd[0] <= regmem[0][addr_o[0]];
        rd[1] <= regmem[1][addr_o[1]];
    end

    always @(negedge clk) begin
        if (we[0]) we_cnt[0]++;
        if (we[1]) we_cnt[1]++;
    end

    typedef struct packed {
        logic       lad_oe;
        logic [3:0] lad;
        logic       ce;
        logic       we;
        logic       oe;
        logic       chk_busy;
        logic       busy;
    } exp_t;

    typedef struct {
        int          inst;
        bit          wr;
        logic [15:0] a;
        logic [7:0]  d;
        bit          claim;
    } vec_t;

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s inst%0d cyc%0d: got %0h want %0h", nm, cur_inst, cur_cyc, act, want);
        end
    endtask

    // Expected bus-visible behaviour at cycle c (cycle 0 = START clock).
    function automatic exp_t model(input int c, input int w, input bit wr,
                                   input bit claim, input logic [7:0] rdat);
        exp_t e;
        int   s;
        int   rdy;
        int   ptar1;
        e = '0;
        e.lad = 4'hF;
        if (!claim) return e;
        s     = wr ? 10 : 8;
        rdy   = s + w;
        ptar1 = wr ? rdy + 1 : rdy + 3;
        if (c >= s && c <= ptar1) e.lad_oe = 1'b1;
        if (c >= s && c < rdy) e.lad = 4'b0101;
        else if (c == rdy) e.lad = 4'b0000;
        else if (!wr && c == rdy + 1) e.lad = rdat[3:0];
        else if (!wr && c == rdy + 2) e.lad = rdat[7:4];
        if (wr) begin
            e.ce = (c == rdy);
            e.we = (c == rdy);
        end else begin
            e.ce = (c >= 6 && c <= rdy);
            e.oe = (c >= 6 && c <= rdy);
        end
        if (c == rdy) begin
            e.chk_busy = 1'b1;
            e.busy     = 1'b1;
        end else if (c == ptar1 + 2) begin
            e.chk_busy = 1'b1;
            e.busy     = 1'b0;
        end
        return e;
    endfunction

    task automatic chk_reset(input int inst);
        chk8("rst_lad",    {4'b0, lad_o[inst]},  8'h0F);
        chk8("rst_lad_oe", {7'b0, lad_oe[inst]}, 8'h00);
        chk8("rst_ce",     {7'b0, ce[inst]},     8'h00);
        chk8("rst_we",     {7'b0, we[inst]},     8'h00);
        chk8("rst_oe",     {7'b0, oe[inst]},     8'h00);
        chk8("rst_addr",   {6'b0, addr_o[inst]}, 8'h00);
        chk8("rst_data",   data_o[inst],         8'h00);
        chk8("rst_busy",   {7'b0, busy[inst]},   8'h00);
    endtask

    // Called positioned on a negedge; returns on a negedge without driving it.
    // stop_at >= 0 cuts the cycle short there (abort), or pulses reset if do_rst.
    task automatic run_txn(input int inst, input bit wr, input logic [15:0] a,
                           input logic [7:0] d, input bit claim, input bit chk0,
                           input int stop_at, input bit do_rst);
        int   w;
        int   last;
        exp_t e;
        w    = (inst == 1) ? 3 : 0;
        last = claim ? 13 + w : 14;
        cur_inst = inst;
        for (int i = 0; i < 4; i++)
            regmem[inst][i] = (i == int'(a[1:0])) ? d : (~d ^ 8'(i));
        for (int c = 0; c <= last; c++) begin
            if (c > 0) @(negedge clk);
            cur_cyc = c;
            if (c == stop_at && !do_rst) return;
            e = model(c, w, wr, claim, d);
            if (c > 0 || chk0) begin
                chk8("lad_oe", {7'b0, lad_oe[inst]}, {7'b0, e.lad_oe});
                if (e.lad_oe) chk8("lad", {4'b0, lad_o[inst]}, {4'b0, e.lad});
                chk8("ce", {7'b0, ce[inst]}, {7'b0, e.ce});
                chk8("we", {7'b0, we[inst]}, {7'b0, e.we});
                chk8("oe", {7'b0, oe[inst]}, {7'b0, e.oe});
                if (e.ce) chk8("addr", {6'b0, addr_o[inst]}, {6'b0, a[1:0]});
                if (e.we) chk8("wdata", data_o[inst], d);
                if (e.chk_busy) chk8("busy", {7'b0, busy[inst]}, {7'b0, e.busy});
            end
            if (c == last) return;
            if (c == stop_at) begin
                rst[inst]      = 1'b1;
                lframe_n[inst] = 1'b1;
                @(negedge clk);
                chk_reset(inst);
                rst[inst] = 1'b0;
                return;
            end
            if (c == 0) begin
                lframe_n[inst] = 1'b0;
                lad_i[inst]    = 4'h0;
            end else begin
                lframe_n[inst] = 1'b1;
                if (c == 1)                lad_i[inst] = {2'b00, wr, 1'($urandom)};
                else if (c <= 5)           lad_i[inst] = a[4*(5-c) +: 4];
                else if (wr && c == 6)     lad_i[inst] = d[3:0];
                else if (wr && c == 7)     lad_i[inst] = d[7:4];
                else                       lad_i[inst] = 4'($urandom);
            end
        end
    endtask

    initial begin
        vec_t        tv [8];
        int          wc;
        bit          wr;
        logic [15:0] a;
        logic [7:0]  d;

        tv[0] = '{0, 1'b1, 16'h0A00, 8'hC3, 1'b1};
        tv[1] = '{0, 1'b0, 16'h0A01, 8'h41, 1'b1};
        tv[2] = '{0, 1'b1, 16'h0B00, 8'h5A, 1'b0};
        tv[3] = '{0, 1'b0, 16'h0A04, 8'h77, 1'b0};
        tv[4] = '{0, 1'b0, 16'h0A03, 8'hE8, 1'b1};
        tv[5] = '{1, 1'b0, 16'h0A03, 8'h96, 1'b1};
        tv[6] = '{1, 1'b1, 16'h0A01, 8'h3C, 1'b1};
        tv[7] = '{1, 1'b1, 16'h09FF, 8'h11, 1'b0};

        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; lframe_n[k] = 1'b1; lad_i[k] = 4'h0;
            for (int i = 0; i < 4; i++) regmem[k][i] = 8'h00;
        end
        @(negedge clk);
        @(negedge clk);
        cur_cyc = 0;
        for (int k = 0; k < 2; k++) begin
            cur_inst = k;
            chk_reset(k);
            rst[k] = 1'b0;
        end

        // Directed table, issued back to back per instance.
        for (int i = 0; i < 8; i++)
            run_txn(tv[i].inst, tv[i].wr, tv[i].a, tv[i].d, tv[i].claim, 1'b1, -1, 1'b0);

        // Restart during the 3rd address nibble: exactly one write must result.
        wc = we_cnt[0];
        run_txn(0, 1'b1, 16'h0A02, 8'hA5, 1'b1, 1'b1, 4, 1'b0);
        run_txn(0, 1'b1, 16'h0A02, 8'h5A, 1'b1, 1'b1, -1, 1'b0);
        chk8("we_pulses", 8'(we_cnt[0] - wc), 8'd1);

        // Restart mid-HTAR of a read: strobes must fall right after.
        run_txn(0, 1'b0, 16'h0A01, 8'h24, 1'b1, 1'b1, 7, 1'b0);
        run_txn(0, 1'b1, 16'h0A03, 8'h81, 1'b1, 1'b0, -1, 1'b0);

        // LFRAME# low with non-START LAD while driving read data.
        run_txn(0, 1'b0, 16'h0A02, 8'hB7, 1'b1, 1'b1, 9, 1'b0);
        lframe_n[0] = 1'b0;
        lad_i[0]    = 4'hA;
        @(negedge clk);
        cur_cyc = 10;
        chk8("abort_lad_oe", {7'b0, lad_oe[0]}, 8'h00);
        chk8("abort_ce",     {7'b0, ce[0]},     8'h00);
        chk8("abort_oe",     {7'b0, oe[0]},     8'h00);
        chk8("abort_busy",   {7'b0, busy[0]},   8'h00);
        lframe_n[0] = 1'b1;
        run_txn(0, 1'b0, 16'h0A00, 8'h6D, 1'b1, 1'b1, -1, 1'b0);

        // Reset during read SYNC waits, then a clean read.
        run_txn(1, 1'b0, 16'h0A01, 8'hF0, 1'b1, 1'b1, 9, 1'b1);
        run_txn(1, 1'b0, 16'h0A01, 8'h2E, 1'b1, 1'b1, -1, 1'b0);

        // Random traffic; window hit decided purely from the address value.
        for (int i = 0; i < 24; i++) begin
            wr = 1'($urandom);
            d  = 8'($urandom);
            if ($urandom_range(0, 1) == 1) a = 16'h0A00 + 16'($urandom_range(0, 3));
            else                           a = 16'($urandom);
            run_txn(i % 2, wr, a, d, (a >= 16'h0A00 && a <= 16'h0A03), 1'b1, -1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lpc_io_slave.md
# lpc_io_slave

LPC bus front end that decodes host I/O read and I/O write cycles from LFRAME#/LAD[3:0] and converts them into the single-cycle ce/we/oe/addr/data strobes consumed by the LPC register block. It owns all LAD turnaround, SYNC and data-nibble sequencing, and claims only a 4-byte I/O window. It sits between the board LPC pins and the register file, in the LPC clock domain.

## Interface
- BASE_ADDR, 16'h0A00: I/O window base; must be 4-byte aligned; window = BASE_ADDR..BASE_ADDR+3.
- SYNC_WAIT, 0: number of short-wait SYNC cycles (LAD=4'b0101) before ready SYNC; range 0..15.

- i_lpc_clk  in  1  LPC clock (33 MHz); all logic on rising edge.
- i_lpc_rst  in  1  reset: one clock; reset is synchronous and active-high.
- i_lframe_n  in  1  LFRAME#, active low.
- i_lad  in  4  LAD input (pin receive path).
- o_lad  out  4  LAD drive value.
- o_lad_oe  out  1  LAD output enable; 1 = block drives pins.
- o_lpc_ce  out  1  register chip enable.
- o_lpc_we  out  1  register write strobe.
- o_lpc_oe  out  1  register read enable.
- o_lpc_addr  out  2  register address = host address[1:0].
- o_lpc_data  out  8  write data to register block.
- i_lpc_data  in  8  read data from register block (registered there; valid one clock after o_lpc_addr/o_lpc_oe stable).
- o_busy  out  1  high while a claimed cycle is in progress.

## Operation
- States: IDLE, CYC, ADDR, WDATA, HTAR, SYNC, RDATA, PTAR. 2-bit nibble counter, 4-bit wait counter.
- START: any clock with i_lframe_n=0 and i_lad=4'b0000 -> CYC, from any state (abort + restart). i_lframe_n=0 with other LAD -> IDLE, release LAD, drop all strobes.
- CYC (i_lframe_n=1): LAD[3:1]=3'b000 -> I/O read; 3'b001 -> I/O write; anything else -> IDLE. LAD[0] ignored.
- ADDR: 4 nibbles, MSB first, shifted into 16-bit address. After 4th nibble: addr[15:2]!=BASE_ADDR[15:2] -> IDLE (cycle ignored, LAD never driven); else write -> WDATA, read -> HTAR.
- WDATA: 2 nibbles, low nibble first, into o_lpc_data; -> HTAR.
- HTAR: 2 clocks, host turnaround, LAD not driven; -> SYNC.
- SYNC: SYNC_WAIT clocks driving 4'b0101, then one ready clock driving 4'b0000. Write -> PTAR; read -> RDATA.
- RDATA: drive captured read byte, low nibble then high nibble; -> PTAR.
- PTAR: clock 1 drive 4'b1111, clock 2 release (o_lad_oe=0); -> IDLE.
- Register strobes: o_lpc_addr loaded after 4th address nibble and held until IDLE. Write: o_lpc_ce=o_lpc_we=1 for exactly the ready-SYNC clock. Read: o_lpc_ce=o_lpc_oe=1 from first HTAR clock through ready-SYNC clock; i_lpc_data captured at end of ready-SYNC clock.
- o_lad/o_lad_oe decoded from state register only (no combinational path from i_lad/i_lframe_n).
- Abort (i_lframe_n low) in any claimed state: strobes low and LAD released on the same clock the abort is sampled; partial write never issued.

## Timing
- Cycle 0 = START clock. Cycle 1 CYC, cycles 2-5 ADDR.
- Write, SYNC_WAIT=W: WDATA 6-7, HTAR 8-9, SYNC 10..10+W (we pulse at 10+W), PTAR 11+W..12+W, IDLE 13+W.
- Read: HTAR 6-7, SYNC 8..8+W (capture at 8+W), RDATA 9+W..10+W, PTAR 11+W..12+W.
- o_lad_oe=1 only in SYNC, RDATA, PTAR clock 1.
- Reset values: o_lad=4'b1111, o_lad_oe=0, o_lpc_ce=0, o_lpc_we=0, o_lpc_oe=0, o_lpc_addr=0, o_lpc_data=0, o_busy=0, state IDLE. Reset asserted mid-cycle -> all of the above at next edge, even during SYNC/RDATA.
- Back-to-back: START accepted in the cycle immediately after PTAR clock 2.

## Test plan
- I/O write 0x0A00 data 0xC3, W=0 -> o_lpc_we/o_lpc_ce high exactly cycle 10, o_lpc_addr=0, o_lpc_data=0xC3; LAD 0000 at 10, 1111 at 11, released 12.
- I/O read 0x0A01, register returns 0x41 -> o_lpc_oe cycles 6-8, LAD 0000 at 8, 0x1 at 9, 0x4 at 10, 1111 at 11.
- Write to 0x0B00 and read of 0x0A04 -> o_lad_oe, o_lpc_ce, o_lpc_we never asserted; block returns to IDLE at cycle 6.
- SYNC_WAIT=3 read 0x0A03 -> LAD 0101 at cycles 8-10, 0000 at 11, data at 12-13.
- LFRAME# low with LAD=0000 during 3rd ADDR nibble, then full write 0x0A02 data 0x5A -> only one we pulse, data 0x5A, address 2.
- i_lpc_rst asserted one clock during read SYNC -> o_lad_oe=0 and all strobes 0 next edge; subsequent read 0x0A01 completes normally.
